// File: rtl/pe_spad_loader_if.sv
// Handshake and spad-write bundle between the GLB/PE controller and pe_spad_loader.
interface pe_spad_loader_if #(
  parameter int MAX_CONFIG_WIDTH = 5,
  parameter int DATA_WIDTH       = 8
);
  logic                        en;
  logic [MAX_CONFIG_WIDTH-1:0] filter_size;
  logic [DATA_WIDTH-1:0]       iact_in_data;
  logic                        iact_in_valid;
  logic                        iact_in_ready;
  logic [DATA_WIDTH-1:0]       weight_in_data;
  logic                        weight_in_valid;
  logic                        weight_in_ready;
  logic                        iact_wr_en;
  logic [MAX_CONFIG_WIDTH-1:0] iact_wr_addr;
  logic [DATA_WIDTH-1:0]       iact_wr_data;
  logic                        weight_wr_en;
  logic [MAX_CONFIG_WIDTH-1:0] weight_wr_addr;
  logic [DATA_WIDTH-1:0]       weight_wr_data;
  logic                        spad_release;
  logic                        iact_spad_ready;
  logic                        weight_spad_ready;
  logic                        busy;

  modport slave (
    input  en, filter_size, spad_release,
    input  iact_in_data, iact_in_valid, weight_in_data, weight_in_valid,
    output iact_in_ready, weight_in_ready,
    output iact_wr_en, iact_wr_addr, iact_wr_data,
    output weight_wr_en, weight_wr_addr, weight_wr_data,
    output iact_spad_ready, weight_spad_ready, busy
  );

  modport master (
    output en, filter_size, spad_release,
    output iact_in_data, iact_in_valid, weight_in_data, weight_in_valid,
    input  iact_in_ready, weight_in_ready,
    input  iact_wr_en, iact_wr_addr, iact_wr_data,
    input  weight_wr_en, weight_wr_addr, weight_wr_data,
    input  iact_spad_ready, weight_spad_ready, busy
  );
endinterface

// File: rtl/pe_spad_loader.sv
// Fills the PE iact and weight scratchpads from GLB beats; each channel holds its
// spad full until the PE controller releases it. Channel 0 = iact, channel 1 = weight.
module pe_spad_loader #(
  parameter int MAX_CONFIG_WIDTH = 5,
  parameter int DATA_WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  pe_spad_loader_if.slave  bus
);
  localparam int CW = MAX_CONFIG_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic {S_FILL, S_FULL} state_t;

  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [1:0]    wr_en;
  logic [1:0]    spad_ready;
  logic [1:0]    busy_ch;
  logic [CW-1:0] wr_addr [2];

  assign in_valid = {bus.weight_in_valid, bus.iact_in_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [CW-1:0] wcnt_reg, wcnt_next;
      logic [CW-1:0] len_reg, len_next;
      logic [CW-1:0] cur_len;
      logic          accept;

      // The first beat of a fill compares against the length it is latching.
      assign cur_len = (wcnt_reg != '0)        ? len_reg :
                       (bus.filter_size == '0) ? CW'(1)  : bus.filter_size;

      assign in_ready[gi] = rstn & bus.en & (state_reg == S_FILL);
      assign accept       = in_valid[gi] & in_ready[gi];

      always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        len_next   = len_reg;
        if (bus.en) begin
          if (state_reg == S_FILL) begin
            if (accept) begin
              len_next = cur_len;
              if (wcnt_reg == cur_len - CW'(1)) begin
                wcnt_next  = '0;
                state_next = S_FULL;
              end else begin
                wcnt_next = wcnt_reg + CW'(1);
              end
            end
          end else if (bus.spad_release) begin
            state_next = S_FILL;
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_reg <= S_FILL;
          wcnt_reg  <= '0;
          len_reg   <= '0;
        end else begin
          state_reg <= state_next;
          wcnt_reg  <= wcnt_next;
          len_reg   <= len_next;
        end
      end

      assign wr_en[gi]      = accept;
      assign wr_addr[gi]    = wcnt_reg;
      assign spad_ready[gi] = (state_reg == S_FULL);
      assign busy_ch[gi]    = (state_reg == S_FILL) && (wcnt_reg != '0);
    end
  endgenerate

  assign bus.iact_in_ready     = in_ready[0];
  assign bus.weight_in_ready   = in_ready[1];
  assign bus.iact_wr_en        = wr_en[0];
  assign bus.weight_wr_en      = wr_en[1];
  assign bus.iact_wr_addr      = wr_addr[0];
  assign bus.weight_wr_addr    = wr_addr[1];
  // Data is gated so every output reads zero while reset is held.
  assign bus.iact_wr_data      = rstn ? bus.iact_in_data   : {DW{1'b0}};
  assign bus.weight_wr_data    = rstn ? bus.weight_in_data : {DW{1'b0}};
  assign bus.iact_spad_ready   = spad_ready[0];
  assign bus.weight_spad_ready = spad_ready[1];
  assign bus.busy              = |busy_ch;
endmodule

// File: tb/tb_pe_spad_loader.sv
// Directed bench for pe_spad_loader: fill, gaps, release, same-cycle release, length latch, reset/en.
module tb_pe_spad_loader;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  pe_spad_loader_if #(.MAX_CONFIG_WIDTH(5), .DATA_WIDTH(8)) bus ();

  pe_spad_loader #(.MAX_CONFIG_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock of stimulus; checks the combinational write strobes mid-cycle.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic wv, input logic [7:0] wd,
                     input logic rel, input logic eie, input logic [4:0] eia,
                     input logic ewe, input logic [4:0] ewa);
    bus.iact_in_valid   = iv;
    bus.iact_in_data    = id;
    bus.weight_in_valid = wv;
    bus.weight_in_data  = wd;
    bus.spad_release    = rel;
    #1;
    chk("iact_wr_en", 32'(bus.iact_wr_en), 32'(eie));
    if (eie) begin
      chk("iact_wr_addr", 32'(bus.iact_wr_addr), 32'(eia));
      chk("iact_wr_data", 32'(bus.iact_wr_data), 32'(id));
    end
    chk("weight_wr_en", 32'(bus.weight_wr_en), 32'(ewe));
    if (ewe) begin
      chk("weight_wr_addr", 32'(bus.weight_wr_addr), 32'(ewa));
      chk("weight_wr_data", 32'(bus.weight_wr_data), 32'(wd));
    end
    $display("cyc t=%0t iv=%0b wv=%0b rel=%0b iwe=%0b ia=%0d wwe=%0b wa=%0d",
             $time, iv, wv, rel, bus.iact_wr_en, bus.iact_wr_addr, bus.weight_wr_en, bus.weight_wr_addr);
    @(posedge clk);
    #1;
    bus.iact_in_valid   = 1'b0;
    bus.weight_in_valid = 1'b0;
    bus.spad_release    = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic ir, input logic wr,
                            input logic isr, input logic wsr, input logic bsy);
    chk({tag, ".iact_in_ready"},     32'(bus.iact_in_ready),     32'(ir));
    chk({tag, ".weight_in_ready"},   32'(bus.weight_in_ready),   32'(wr));
    chk({tag, ".iact_spad_ready"},   32'(bus.iact_spad_ready),   32'(isr));
    chk({tag, ".weight_spad_ready"}, 32'(bus.weight_spad_ready), 32'(wsr));
    chk({tag, ".busy"},              32'(bus.busy),              32'(bsy));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    bus.en = 1'b1;
    bus.filter_size = 5'd3;
    bus.iact_in_valid = 1'b0;
    bus.iact_in_data = 8'h00;
    bus.weight_in_valid = 1'b0;
    bus.weight_in_data = 8'h00;
    bus.spad_release = 1'b0;
    #12;
    chk_status("reset", 0, 0, 0, 0, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_status("idle", 1, 1, 0, 0, 0);

    // iact back-to-back, filter_size=3
    cyc(1, 8'h11, 0, 8'h00, 0, 1, 5'd0, 0, 5'd0);
    chk("busy_after_first", 32'(bus.busy), 32'd1);
    cyc(1, 8'h22, 0, 8'h00, 0, 1, 5'd1, 0, 5'd0);
    cyc(1, 8'h33, 0, 8'h00, 0, 1, 5'd2, 0, 5'd0);
    chk_status("iact_full", 0, 1, 1, 0, 0);

    // weight with valid gaps
    cyc(0, 8'h00, 1, 8'hA1, 0, 0, 5'd0, 1, 5'd0);
    cyc(0, 8'h00, 0, 8'h00, 0, 0, 5'd0, 0, 5'd0);
    cyc(0, 8'h00, 1, 8'hA2, 0, 0, 5'd0, 1, 5'd1);
    cyc(0, 8'h00, 0, 8'h00, 0, 0, 5'd0, 0, 5'd0);
    cyc(0, 8'h00, 1, 8'hA3, 0, 0, 5'd0, 1, 5'd2);
    chk_status("both_full", 0, 0, 1, 1, 0);

    // release both, refill with filter_size=5
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0, 5'd0);
    chk_status("released", 1, 1, 0, 0, 0);
    bus.filter_size = 5'd5;
    for (int i = 0; i < 5; i++)
      cyc(1, 8'(8'h50 + i), 1, 8'(8'h90 + i), 0, 1, 5'(i), 1, 5'(i));
    chk_status("refill5_full", 0, 0, 1, 1, 0);

    // iact last beat coincides with release while weight is full
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0, 5'd0);
    bus.filter_size = 5'd2;
    cyc(1, 8'h71, 1, 8'h81, 0, 1, 5'd0, 1, 5'd0);
    cyc(0, 8'h00, 1, 8'h82, 0, 0, 5'd0, 1, 5'd1);
    chk_status("w_full_i_partial", 1, 0, 0, 1, 1);
    cyc(1, 8'h72, 0, 8'h00, 1, 1, 5'd1, 0, 5'd0);
    chk_status("same_cycle_rel", 0, 1, 1, 0, 0);
    cyc(0, 8'h00, 0, 8'h00, 0, 0, 5'd0, 0, 5'd0);
    chk("iact_holds_ready", 32'(bus.iact_spad_ready), 32'd1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0, 5'd0);
    chk_status("second_rel", 1, 1, 0, 0, 0);

    // filter_size=0 acts as 1; mid-fill filter_size change ignored
    bus.filter_size = 5'd0;
    cyc(1, 8'h55, 0, 8'h00, 0, 1, 5'd0, 0, 5'd0);
    chk("fs0_iact_ready", 32'(bus.iact_spad_ready), 32'd1);
    bus.filter_size = 5'd3;
    cyc(0, 8'h00, 1, 8'h61, 0, 0, 5'd0, 1, 5'd0);
    bus.filter_size = 5'd7;
    cyc(0, 8'h00, 1, 8'h62, 0, 0, 5'd0, 1, 5'd1);
    cyc(0, 8'h00, 1, 8'h63, 0, 0, 5'd0, 1, 5'd2);
    chk_status("fs_change_full", 0, 0, 1, 1, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0, 5'd0);

    // reset mid-fill, then en stall
    bus.filter_size = 5'd4;
    cyc(1, 8'hC0, 0, 8'h00, 0, 1, 5'd0, 0, 5'd0);
    cyc(1, 8'hC1, 0, 8'h00, 0, 1, 5'd1, 0, 5'd0);
    rstn = 1'b0;
    bus.iact_in_valid = 1'b1;
    bus.iact_in_data = 8'hEE;
    bus.weight_in_valid = 1'b1;
    bus.weight_in_data = 8'hDD;
    #1;
    chk_status("in_reset", 0, 0, 0, 0, 0);
    chk("rst_iact_wr_en", 32'(bus.iact_wr_en), 32'd0);
    chk("rst_weight_wr_en", 32'(bus.weight_wr_en), 32'd0);
    chk("rst_iact_wr_data", 32'(bus.iact_wr_data), 32'd0);
    chk("rst_weight_wr_data", 32'(bus.weight_wr_data), 32'd0);
    chk("rst_iact_wr_addr", 32'(bus.iact_wr_addr), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.iact_in_valid = 1'b0;
    bus.weight_in_valid = 1'b0;
    cyc(1, 8'hC2, 0, 8'h00, 0, 1, 5'd0, 0, 5'd0);
    bus.en = 1'b0;
    cyc(1, 8'hC3, 1, 8'hD3, 0, 0, 5'd0, 0, 5'd0);
    chk("en_low_iact_ready", 32'(bus.iact_in_ready), 32'd0);
    chk("en_low_weight_ready", 32'(bus.weight_in_ready), 32'd0);
    bus.en = 1'b1;
    cyc(1, 8'hC4, 0, 8'h00, 0, 1, 5'd1, 0, 5'd0);
    chk("post_stall_busy", 32'(bus.busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
